// File: rtl/dm_responder_if.sv
// Core-to-data-memory request/response bundle for dm_responder.
// DM_perr_inject exists only when DM_PARITY_EN is defined.
interface dm_responder_if #(
  parameter int DataSize = 32,
  parameter int AddrSize = 12
);
  logic                DM_enable;
  logic                DM_read;
  logic                DM_write;
  logic [AddrSize-1:0] DM_address;
  logic [DataSize-1:0] DM_in;
`ifdef DM_PARITY_EN
  logic                DM_perr_inject;
`endif
  logic [DataSize-1:0] DM_out;
  logic                DM_ready;
  logic                DM_rvalid;
  logic                DM_perr;

`ifdef DM_PARITY_EN
  modport master (
    output DM_enable, DM_read, DM_write,
    output DM_address, DM_in, DM_perr_inject,
    input  DM_out, DM_ready, DM_rvalid, DM_perr
  );
  modport slave (
    input  DM_enable, DM_read, DM_write,
    input  DM_address, DM_in, DM_perr_inject,
    output DM_out, DM_ready, DM_rvalid, DM_perr
  );
`else
  modport master (
    output DM_enable, DM_read, DM_write,
    output DM_address, DM_in,
    input  DM_out, DM_ready, DM_rvalid, DM_perr
  );
  modport slave (
    input  DM_enable, DM_read, DM_write,
    input  DM_address, DM_in,
    output DM_out, DM_ready, DM_rvalid, DM_perr
  );
`endif
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: single-port word store with WAIT_STATES busy cycles.
// Optional even-parity storage and error reporting via DM_PARITY_EN.
module dm_responder #(
  parameter int DataSize    = 32,
  parameter int AddrSize    = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);

`ifdef DM_PARITY_EN
  localparam int MW = DataSize + 1;
`else
  localparam int MW = DataSize;
`endif
  localparam logic [3:0] CNT_INIT =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic                op_wr;
  logic [AddrSize-1:0] op_addr;
  logic [DataSize-1:0] op_data;

  logic                accept, fire, f_wr;
  logic [AddrSize-1:0] f_addr;
  logic [DataSize-1:0] f_data;
  logic [MW-1:0]       wword, rword;
  logic                perr_bit;

  logic [MW-1:0] mem [2**AddrSize];

  always_comb begin
    accept  = (state == IDLE) && bus.DM_enable
            && (bus.DM_read || bus.DM_write);
    state_n = state;
    cnt_n   = cnt;
    // Zero wait states completes at the accept edge from live inputs
    if (WAIT_STATES == 0) begin
      fire   = accept;
      f_wr   = bus.DM_write;
      f_addr = bus.DM_address;
      f_data = bus.DM_in;
    end else begin
      fire   = (state == BUSY) && (cnt == 4'd0);
      f_wr   = op_wr;
      f_addr = op_addr;
      f_data = op_data;
    end
    unique case (1'b1)
      (state == IDLE): begin
        if (accept && (WAIT_STATES != 0)) begin
          state_n = BUSY;
          cnt_n   = CNT_INIT;
        end
      end
      (state == BUSY): begin
        if (cnt == 4'd0) state_n = IDLE;
        else cnt_n = cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr   <= bus.DM_write;
      op_addr <= bus.DM_address;
      op_data <= bus.DM_in;
    end
  end

`ifdef DM_PARITY_EN
  logic op_inj, f_inj;

  always_ff @(posedge clk) begin
    if (accept) op_inj <= bus.DM_perr_inject;
  end

  always_comb begin
    f_inj    = (WAIT_STATES == 0) ? bus.DM_perr_inject : op_inj;
    wword    = {(^f_data) ^ f_inj, f_data};
    perr_bit = ^rword;
  end
`else
  always_comb begin
    wword    = f_data;
    perr_bit = 1'b0;
  end
`endif

  assign rword        = mem[f_addr];
  assign bus.DM_ready = (state == IDLE);

  // Array is intentionally left out of reset
  always_ff @(posedge clk) begin
    if (!reset && fire && f_wr) mem[f_addr] <= wword;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.DM_out    <= '0;
      bus.DM_rvalid <= 1'b0;
      bus.DM_perr   <= 1'b0;
    end else begin
      bus.DM_rvalid <= fire && !f_wr;
      bus.DM_perr   <= fire && !f_wr && perr_bit;
      if (fire && !f_wr) bus.DM_out <= rword[DataSize-1:0];
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder at WAIT_STATES 0, 1 and 3.
// Parity scenario is compiled in when DM_PARITY_EN is defined.
module tb_dm_responder;

  logic clk;
  logic rst0, rst1, rst3;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp_q[$];
  int          cyc_q[$];

  dm_responder_if #(.DataSize(32), .AddrSize(12)) b0 ();
  dm_responder_if #(.DataSize(32), .AddrSize(12)) b1 ();
  dm_responder_if #(.DataSize(32), .AddrSize(12)) b3 ();

  dm_responder #(.DataSize(32), .AddrSize(12), .WAIT_STATES(0))
    u0 (.clk(clk), .reset(rst0), .bus(b0));
  dm_responder #(.DataSize(32), .AddrSize(12), .WAIT_STATES(1))
    u1 (.clk(clk), .reset(rst1), .bus(b1));
  dm_responder #(.DataSize(32), .AddrSize(12), .WAIT_STATES(3))
    u3 (.clk(clk), .reset(rst3), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int w, input logic en, rd, wr,
                       input logic [11:0] a, input logic [31:0] d);
    case (w)
      0: begin
        b0.DM_enable = en; b0.DM_read = rd; b0.DM_write = wr;
        b0.DM_address = a; b0.DM_in = d;
      end
      1: begin
        b1.DM_enable = en; b1.DM_read = rd; b1.DM_write = wr;
        b1.DM_address = a; b1.DM_in = d;
      end
      default: begin
        b3.DM_enable = en; b3.DM_read = rd; b3.DM_write = wr;
        b3.DM_address = a; b3.DM_in = d;
      end
    endcase
  endtask

  // Waits (bounded) for rvalid, counting cycles with ready low
  task automatic wait_rv(input int w, output bit seen, output int lows);
    logic rv, rdy;
    seen = 1'b0;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      rv  = (w == 0) ? b0.DM_rvalid : (w == 1) ? b1.DM_rvalid : b3.DM_rvalid;
      rdy = (w == 0) ? b0.DM_ready  : (w == 1) ? b1.DM_ready  : b3.DM_ready;
      if (rv === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (rdy !== 1'b1) lows++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst1 = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (b1.DM_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_ready: got %b want 1", b1.DM_ready);
    end
    n_cmp++;
    if (b1.DM_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rst_rvalid: got %b want 0", b1.DM_rvalid);
    end
    n_cmp++;
    if (b1.DM_out !== 32'h0) begin
      n_err++; $display("FAIL rst_out: got %h want 0", b1.DM_out);
    end
    n_cmp++;
    if (b1.DM_perr !== 1'b0) begin
      n_err++; $display("FAIL rst_perr: got %b want 0", b1.DM_perr);
    end
    rst1 = 1'b0;
  endtask

  task automatic test_write_read;
    bit seen; int lows; logic [31:0] e;
    drive(1, 1, 0, 1, 12'h00A, 32'hDEADBEEF);
    @(negedge clk);
    n_cmp++;
    if (b1.DM_ready !== 1'b0) begin
      n_err++; $display("FAIL wr_busy: ready got %b want 0", b1.DM_ready);
    end
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (b1.DM_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_done: ready got %b want 1", b1.DM_ready);
    end
    drive(1, 1, 1, 0, 12'h00A, 0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    wait_rv(1, seen, lows);
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL rd_rvalid: got timeout want pulse");
    end
    n_cmp++;
    if (lows != 1) begin
      n_err++; $display("FAIL rd_busy_len: got %0d want 1", lows);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (b1.DM_out !== e) begin
      n_err++; $display("FAIL rd_data: got %h want %h", b1.DM_out, e);
    end
    @(negedge clk);
    n_cmp++;
    if (b1.DM_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rd_pulse: rvalid got %b want 0", b1.DM_rvalid);
    end
  endtask

  task automatic test_back_to_back;
    logic        op_w[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    logic [11:0] op_a[8] = '{12'h001, 12'h002, 12'h001, 12'h002,
                             12'hFFF, 12'h000, 12'hFFF, 12'h000};
    logic [31:0] op_d[8] = '{32'h11, 32'h22, 0, 0,
                             32'hF0F0F0F0, 32'h0F0F0F0F, 0, 0};
    logic [31:0] mdl[int];
    logic [31:0] e;
    int          c;
    rst0 = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst0 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (b0.DM_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, b0.DM_ready);
      end
      if (b0.DM_rvalid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra[%0d]: got rvalid want none", i);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          if (b0.DM_out !== e || c != i) begin
            n_err++;
            $display("FAIL b2b_read[%0d]: got %h @%0d want %h @%0d",
                     i, b0.DM_out, i, e, c);
          end
        end
      end
      if (i < 8) begin
        drive(0, 1, !op_w[i], op_w[i], op_a[i], op_d[i]);
        if (op_w[i]) mdl[int'(op_a[i])] = op_d[i];
        else begin
          exp_q.push_back(mdl[int'(op_a[i])]);
          cyc_q.push_back(i + 1);
        end
      end else drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_missing: got %0d left want 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic test_ignored;
    bit seen; int lows; logic [31:0] e;
    drive(1, 1, 0, 1, 12'h030, 32'h00000BAD);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 1, 12'h020, 32'h00001234);
    @(negedge clk);
    drive(1, 1, 0, 1, 12'h030, 32'hFFFFFFFF);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? 32'h00000BAD : 32'h00001234;
      drive(1, 1, 1, 0, (k == 0) ? 12'h030 : 12'h020, 0);
      exp_q.push_back(e);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0);
      wait_rv(1, seen, lows);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || b1.DM_out !== e) begin
        n_err++;
        $display("FAIL busy_ignore[%0d]: got %h seen=%0b want %h",
                 k, b1.DM_out, seen, e);
      end
      @(negedge clk);
    end
    drive(1, 0, 1, 0, 12'h030, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b1.DM_rvalid !== 1'b0 || b1.DM_ready !== 1'b1 ||
          b1.DM_out !== 32'h00001234) begin
        n_err++;
        $display("FAIL en_low[%0d]: got rv=%b rdy=%b out=%h want 0 1 00001234",
                 i, b1.DM_rvalid, b1.DM_ready, b1.DM_out);
      end
    end
    drive(1, 1, 1, 1, 12'h040, 32'h0000CAFE);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (b1.DM_ready !== 1'b0) begin
      n_err++; $display("FAIL rdwr_busy: ready got %b want 0", b1.DM_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b1.DM_rvalid !== 1'b0) begin
        n_err++; $display("FAIL rdwr_norv[%0d]: got %b want 0", i, b1.DM_rvalid);
      end
    end
    drive(1, 1, 1, 0, 12'h040, 0);
    exp_q.push_back(32'h0000CAFE);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    wait_rv(1, seen, lows);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || b1.DM_out !== e) begin
      n_err++;
      $display("FAIL rdwr_data: got %h seen=%0b want %h", b1.DM_out, seen, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_busy;
    bit seen; int lows; logic [31:0] e;
    rst3 = 1'b1;
    drive(3, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst3 = 1'b0;
    drive(3, 1, 0, 1, 12'h007, 32'hA5A5A5A5);
    @(negedge clk);
    drive(3, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (b3.DM_ready !== 1'b1) begin
      n_err++; $display("FAIL ws3_done: ready got %b want 1", b3.DM_ready);
    end
    drive(3, 1, 0, 1, 12'h007, 32'h00000055);
    @(negedge clk);
    drive(3, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    n_cmp++;
    if (b3.DM_ready !== 1'b1 || b3.DM_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL midbusy_rst: got rdy=%b rv=%b want 1 0",
               b3.DM_ready, b3.DM_rvalid);
    end
    drive(3, 1, 1, 0, 12'h007, 0);
    exp_q.push_back(32'hA5A5A5A5);
    @(negedge clk);
    drive(3, 0, 0, 0, 0, 0);
    wait_rv(3, seen, lows);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || lows != 3) begin
      n_err++; $display("FAIL ws3_lat: got seen=%0b lows=%0d want 1 3", seen, lows);
    end
    n_cmp++;
    if (b3.DM_out !== e) begin
      n_err++; $display("FAIL midbusy_data: got %h want %h", b3.DM_out, e);
    end
  endtask

  task automatic test_parity;
    bit seen; int lows; logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 0, 1, 12'h050, 32'h00000001);
`ifdef DM_PARITY_EN
      b1.DM_perr_inject = (k == 0);
`endif
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0);
`ifdef DM_PARITY_EN
      b1.DM_perr_inject = 1'b0;
`endif
      @(negedge clk);
      drive(1, 1, 1, 0, 12'h050, 0);
      exp_q.push_back(32'h00000001);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0);
      wait_rv(1, seen, lows);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || b1.DM_out !== e) begin
        n_err++;
        $display("FAIL par_data[%0d]: got %h seen=%0b want %h",
                 k, b1.DM_out, seen, e);
      end
      n_cmp++;
`ifdef DM_PARITY_EN
      if (b1.DM_perr !== (k == 0)) begin
        n_err++;
        $display("FAIL par_err[%0d]: got %b want %b", k, b1.DM_perr, (k == 0));
      end
`else
      if (b1.DM_perr !== 1'b0) begin
        n_err++; $display("FAIL par_tied[%0d]: got %b want 0", k, b1.DM_perr);
      end
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(3, 0, 0, 0, 0, 0);
`ifdef DM_PARITY_EN
    b0.DM_perr_inject = 1'b0;
    b1.DM_perr_inject = 1'b0;
    b3.DM_perr_inject = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_ignored();
    test_reset_busy();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
